fib_report_writer: RTL and testbench
====================================

FIB_REPORT_WRITER -- requirements
Module: fib_report_writer

Interface
REQ-001 SHALL have parameter TEST_PORT, default 30'h0FF, word address of the result test port.
REQ-002 SHALL have parameter BEGIN_SYMBOL, default 32'h00000168, first word of the report.
REQ-003 SHALL have parameter END_SYMBOL, default 32'hFFFFFD5D, last word of the report.
REQ-004 SHALL have parameter N_MAX, default 20, the highest Fibonacci index reported; legal range 1..47.
REQ-005 SHALL have parameter GAP, default 1, the number of idle cycles with mem_wen low between writes; legal range 1..15.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: a level sampled in IDLE or DONE that begins a report.
REQ-009 SHALL have port mem_stall, input, 1 bit: data-memory stall; while high, the current write is not accepted.
REQ-010 SHALL have port mem_addr, output, 30 bits: word address, equal to TEST_PORT whenever mem_wen=1, else 0.
REQ-011 SHALL have port mem_wdata, output, 32 bits: byte-swapped write data {w[7:0],w[15:8],w[23:16],w[31:24]} of logical word w; 0 when mem_wen=0.
REQ-012 SHALL have port mem_wen, output, 1 bit: write enable.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE and DONE.
REQ-014 SHALL have port done, output, 1 bit: high in DONE.
REQ-015 SHALL have port wr_count, output, 7 bits: number of accepted writes in the current report.

Function
REQ-016 SHALL implement states IDLE, WRITE, GAP and DONE, plus a phase register with values BEGIN, UP, DOWN and END.
REQ-017 SHALL, in IDLE or DONE with start=1, go to WRITE next cycle with phase=BEGIN, wr_count=0, cur=0 and nxt=1; start=0 SHALL leave the state unchanged.
REQ-018 SHALL drive mem_wen=1 exactly while in WRITE; the logical word is BEGIN_SYMBOL in BEGIN, cur in UP or DOWN, and END_SYMBOL in END.
REQ-019 SHALL treat a write as accepted on a clock edge where mem_wen=1 and mem_stall=0; while mem_stall=1, WRITE, the word and the address SHALL be held unchanged.
REQ-020 SHALL increment wr_count on each accepted write, saturating at 127.
REQ-021 SHALL, on acceptance, move to GAP for exactly GAP cycles with mem_wen=0 and then return to WRITE; after the END write it SHALL move directly to DONE.
REQ-022 SHALL apply these phase transitions on acceptance: BEGIN to UP; UP with index<N_MAX to UP; UP with index=N_MAX to DOWN; DOWN with index>0 to DOWN; DOWN with index=0 to END.
REQ-023 SHALL, on an accepted UP write with index<N_MAX, update (cur,nxt) to (nxt, cur+nxt) using 32-bit unsigned arithmetic.
REQ-024 SHALL, on the UP write with index=N_MAX, hold (cur,nxt), so that the first DOWN word repeats F(N_MAX).
REQ-025 SHALL, on an accepted DOWN write, update (cur,nxt) to (nxt-cur, cur); the block SHALL use no lookup table.
REQ-026 SHALL emit one report sequence of 2*N_MAX+4 writes: BEGIN, F(0)..F(N_MAX), F(N_MAX)..F(0), END.
REQ-027 SHALL ignore start outside IDLE and DONE, and SHALL ignore mem_stall outside WRITE.
REQ-028 SHALL hold DONE, with done=1 and wr_count frozen, until start or reset.
REQ-029 SHALL, with mem_stall=0 and GAP=g, accept writes on cycles 0, g+1, 2(g+1), and so on, counting from the first mem_wen cycle, and SHALL assert done the cycle after the final acceptance.

Reset
REQ-030 SHALL, while rst=0 (including mid-report), immediately force state=IDLE, phase=BEGIN, mem_wen=0, mem_addr=0, mem_wdata=0, busy=0, done=0, wr_count=0, cur=0 and nxt=1.
REQ-031 SHALL, after rst is released, emit no write until start=1 is sampled.

Verification
REQ-032 Defaults, no stall, start pulsed for 1 cycle -> 44 writes; the logical words are 0x168, 0,1,1,2,...,6765, 6765,...,1,1,0, 0xFFFFFD5D; the first mem_wdata is 32'h68010000; done is asserted 87 cycles after the first mem_wen; wr_count=44.
REQ-033 mem_stall=1 for 5 cycles during the 10th write -> that word (34) is held for 6 cycles, there is no duplicate and no skip, and the total runtime grows by exactly 5 cycles.
REQ-034 N_MAX=1, GAP=3 -> the words are 0x168, 0, 1, 1, 0, 0xFFFFFD5D; each mem_wen pulse is 1 cycle with 3 low cycles between pulses.
REQ-035 N_MAX=47 -> the peak word is 2971215073 with no wrap; the descending run ends at 0; 98 writes in total.
REQ-036 rst driven low during the DOWN phase -> mem_wen drops in the same cycle and all outputs return to reset values; the next start produces a complete, correct report from BEGIN.
REQ-037 start held high through a whole report -> start is ignored while busy; in DONE a new report begins the next cycle and wr_count restarts at 0.

Source files
------------

// File: rtl/fib_report_writer_if.sv
// Write-only data-memory port of the Fibonacci report writer.
// The writer drives address/data/enable; the memory returns a stall.
interface fib_report_writer_if;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic        mem_stall;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_wen,
    input  mem_stall
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_wen,
    output mem_stall
  );
endinterface

// File: rtl/fib_report_writer.sv
// Writes a framed report F(0)..F(N_MAX), F(N_MAX)..F(0) to a memory test port,
// one word per write with GAP idle cycles between writes.
module fib_report_writer #(
  parameter logic [29:0] TEST_PORT    = 30'h0FF,
  parameter logic [31:0] BEGIN_SYMBOL = 32'h00000168,
  parameter logic [31:0] END_SYMBOL   = 32'hFFFFFD5D,
  parameter int          N_MAX        = 20,
  parameter int          GAP          = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  fib_report_writer_if.master mem,
  output logic                busy,
  output logic                done,
  output logic [6:0]          wr_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] PH_BEGIN = 2'd0;
  localparam logic [1:0] PH_UP    = 2'd1;
  localparam logic [1:0] PH_DOWN  = 2'd2;
  localparam logic [1:0] PH_END   = 2'd3;

  localparam logic [5:0] IDX_MAX    = 6'(N_MAX);
  localparam logic [3:0] GAP_RELOAD = 4'(GAP - 1);

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  logic [1:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] cur_q, cur_d;
  logic [31:0] nxt_q, nxt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [6:0]  wr_count_q, wr_count_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept_s;
  logic [31:0] word_s;

  assign accept_s = (state_q == ST_WRITE) && !mem.mem_stall;

  // Sequencing and Fibonacci datapath; the descending run recovers F(i-1) as F(i+1)-F(i).
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    gap_cnt_d  = gap_cnt_q;
    wr_count_d = wr_count_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_WRITE;
          phase_d    = PH_BEGIN;
          idx_d      = 6'd0;
          cur_d      = 32'd0;
          nxt_d      = 32'd1;
          wr_count_d = 7'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_WRITE: begin
        if (accept_s) begin
          wr_count_d = (wr_count_q == 7'd127) ? wr_count_q : wr_count_q + 7'd1;
          gap_cnt_d  = GAP_RELOAD;
          state_d    = ST_GAP;
          case (phase_q)
            PH_BEGIN: phase_d = PH_UP;
            PH_UP: begin
              if (idx_q == IDX_MAX) begin
                phase_d = PH_DOWN;
              end else begin
                idx_d = idx_q + 6'd1;
                cur_d = nxt_q;
                nxt_d = cur_q + nxt_q;
              end
            end
            PH_DOWN: begin
              cur_d = nxt_q - cur_q;
              nxt_d = cur_q;
              if (idx_q == 6'd0) begin
                phase_d = PH_END;
              end else begin
                idx_d = idx_q - 6'd1;
              end
            end
            PH_END:  state_d = ST_DONE;
            default: phase_d = PH_BEGIN;
          endcase
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = ST_WRITE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the next cycle, so every port comes straight from a flop.
  always_comb begin
    case (phase_d)
      PH_BEGIN:       word_s = BEGIN_SYMBOL;
      PH_UP, PH_DOWN: word_s = cur_d;
      PH_END:         word_s = END_SYMBOL;
      default:        word_s = 32'd0;
    endcase
    wen_d = (state_d == ST_WRITE);
    if (wen_d) begin
      addr_d  = TEST_PORT;
      wdata_d = byte_swap(word_s);
    end else begin
      addr_d  = 30'd0;
      wdata_d = 32'd0;
    end
    busy_d = (state_d == ST_WRITE) || (state_d == ST_GAP);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_BEGIN;
      idx_q      <= 6'd0;
      cur_q      <= 32'd0;
      nxt_q      <= 32'd1;
      gap_cnt_q  <= 4'd0;
      wr_count_q <= 7'd0;
      addr_q     <= 30'd0;
      wdata_q    <= 32'd0;
      wen_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      gap_cnt_q  <= gap_cnt_d;
      wr_count_q <= wr_count_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wen   = wen_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_fib_report_writer.sv
// Bench for fib_report_writer: three parameterisations, a scenario table checked
// against a list-of-words reference model, plus reset and held-start sequences.
module tb_fib_report_writer;

  localparam int M_NOSTALL = 0;
  localparam int M_RAND    = 1;
  localparam int M_TARGET  = 2;
  localparam int M_HOLD    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a [3];
  logic        stall_a [3];
  logic        wen_a   [3];
  logic        busy_a  [3];
  logic        done_a  [3];
  logic [29:0] addr_a  [3];
  logic [31:0] wdata_a [3];
  logic [6:0]  wrc_a   [3];

  int nm_t [3] = '{20, 1, 47};
  int gp_t [3] = '{1, 3, 2};

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  fib_report_writer_if bus0 ();
  fib_report_writer_if bus1 ();
  fib_report_writer_if bus2 ();

  fib_report_writer #(.N_MAX(20), .GAP(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .mem(bus0),
    .busy(busy_a[0]), .done(done_a[0]), .wr_count(wrc_a[0]));
  fib_report_writer #(.N_MAX(1), .GAP(3)) dut1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .mem(bus1),
    .busy(busy_a[1]), .done(done_a[1]), .wr_count(wrc_a[1]));
  fib_report_writer #(.N_MAX(47), .GAP(2)) dut2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .mem(bus2),
    .busy(busy_a[2]), .done(done_a[2]), .wr_count(wrc_a[2]));

  assign bus0.mem_stall = stall_a[0];
  assign bus1.mem_stall = stall_a[1];
  assign bus2.mem_stall = stall_a[2];
  assign wen_a[0] = bus0.mem_wen;
  assign wen_a[1] = bus1.mem_wen;
  assign wen_a[2] = bus2.mem_wen;
  assign addr_a[0] = bus0.mem_addr;
  assign addr_a[1] = bus1.mem_addr;
  assign addr_a[2] = bus2.mem_addr;
  assign wdata_a[0] = bus0.mem_wdata;
  assign wdata_a[1] = bus1.mem_wdata;
  assign wdata_a[2] = bus2.mem_wdata;

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference report: BEGIN, F(0)..F(n), F(n)..F(0), END.
  task automatic build_words(input int n);
    longint f [48];
    exp_q.delete();
    f[0] = 0;
    f[1] = 1;
    for (int i = 2; i <= n; i++) f[i] = f[i-1] + f[i-2];
    exp_q.push_back(32'h00000168);
    for (int i = 0; i <= n; i++) exp_q.push_back(f[i][31:0]);
    for (int i = n; i >= 0; i--) exp_q.push_back(f[i][31:0]);
    exp_q.push_back(32'hFFFFFD5D);
  endtask

  task automatic check_reset_outputs(input int k, input string tag);
    chk({tag, "_wen"},   64'(wen_a[k]),   64'd0);
    chk({tag, "_addr"},  64'(addr_a[k]),  64'd0);
    chk({tag, "_wdata"}, 64'(wdata_a[k]), 64'd0);
    chk({tag, "_busy"},  64'(busy_a[k]),  64'd0);
    chk({tag, "_done"},  64'(done_a[k]),  64'd0);
    chk({tag, "_wrc"},   64'(wrc_a[k]),   64'd0);
  endtask

  // Starts a report on DUT k and follows it cycle by cycle against the word list.
  task automatic run_report(input int k, input int mode, output int n_acc, output int run_cyc,
                            output logic [31:0] first_wd, output logic [31:0] peak,
                            output int stalls, output int hold_cnt);
    int pos, gap_left, len, stall_budget, cyc;
    bit running, fin, ew, st;
    build_words(nm_t[k]);
    len = exp_q.size();
    pos = 0; gap_left = 0; stall_budget = 5; running = 1'b1; fin = 1'b0;
    stalls = 0; hold_cnt = 0; run_cyc = -1; first_wd = 32'd0; peak = 32'd0;
    @(negedge clk);
    start_a[k] = 1'b1;
    @(negedge clk);
    if (mode != M_HOLD) start_a[k] = 1'b0;
    for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      ew = running && (gap_left == 0);
      case (mode)
        M_RAND:   st = ($urandom_range(0, 3) == 0);
        M_TARGET: st = ew && (pos == 10) && (stall_budget > 0);
        default:  st = 1'b0;
      endcase
      if (mode == M_TARGET && st) stall_budget--;
      stall_a[k] = st;
      chk("wen", 64'(wen_a[k]), 64'(ew));
      if (ew) begin
        chk("wdata", 64'(wdata_a[k]), 64'(swap32(exp_q[pos])));
        chk("addr", 64'(addr_a[k]), 64'(30'h0FF));
        if (cyc == 0) first_wd = wdata_a[k];
      end else begin
        chk("idle_wdata", 64'(wdata_a[k]), 64'd0);
        chk("idle_addr", 64'(addr_a[k]), 64'd0);
      end
      chk("busy", 64'(busy_a[k]), 64'(running));
      chk("done", 64'(done_a[k]), 64'(!running));
      chk("wr_count", 64'(wrc_a[k]), 64'(pos));
      if (!running) begin
        run_cyc = cyc;
        fin = 1'b1;
      end else if (ew) begin
        if (pos == 10) hold_cnt++;
        if (st) begin
          stalls++;
        end else begin
          if (pos >= 1 && pos <= len - 2 && swap32(wdata_a[k]) > peak) peak = swap32(wdata_a[k]);
          pos++;
          if (pos == len) running = 1'b0;
          else gap_left = gp_t[k];
        end
      end else begin
        gap_left--;
      end
    end
    stall_a[k] = 1'b0;
    n_acc = pos;
    chk("report_completes", 64'(fin), 64'd1);
    if (mode == M_HOLD) begin
      @(negedge clk);
      chk("restart_wen", 64'(wen_a[k]), 64'd1);
      chk("restart_wrc", 64'(wrc_a[k]), 64'd0);
      chk("restart_done", 64'(done_a[k]), 64'd0);
      chk("restart_word", 64'(wdata_a[k]), 64'(swap32(32'h00000168)));
      start_a[k] = 1'b0;
    end
  endtask

  typedef struct {
    int          k;
    int          mode;
    int          exp_writes;
    int          exp_run;
    logic [31:0] exp_first;
    logic [31:0] exp_peak;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int n_acc, run_cyc, stalls, hold_cnt, cnt;
    logic [31:0] first_wd, peak;

    tbl[0] = '{0, M_NOSTALL, 44, 87,  32'h68010000, 32'd6765};
    tbl[1] = '{1, M_NOSTALL, 6,  21,  32'h68010000, 32'd1};
    tbl[2] = '{2, M_NOSTALL, 98, 292, 32'h68010000, 32'd2971215073};
    tbl[3] = '{0, M_TARGET,  44, 87,  32'h68010000, 32'd6765};
    tbl[4] = '{0, M_RAND,    44, 87,  32'h68010000, 32'd6765};
    tbl[5] = '{2, M_RAND,    98, 292, 32'h68010000, 32'd2971215073};

    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0;
      stall_a[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < 3; k++) check_reset_outputs(k, "por");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk("no_write_before_start", 64'(wen_a[k]), 64'd0);
    end

    for (int i = 0; i < 6; i++) begin
      run_report(tbl[i].k, tbl[i].mode, n_acc, run_cyc, first_wd, peak, stalls, hold_cnt);
      chk("tbl_writes", 64'(n_acc), 64'(tbl[i].exp_writes));
      chk("tbl_runtime", 64'(run_cyc), 64'(tbl[i].exp_run + stalls));
      chk("tbl_first_wdata", 64'(first_wd), 64'(tbl[i].exp_first));
      chk("tbl_peak", 64'(peak), 64'(tbl[i].exp_peak));
      chk("tbl_final_wrc", 64'(wrc_a[tbl[i].k]), 64'(tbl[i].exp_writes));
      if (tbl[i].mode == M_TARGET) begin
        chk("target_stalls", 64'(stalls), 64'd5);
        chk("target_hold_cycles", 64'(hold_cnt), 64'd6);
      end
    end

    // Reset in the middle of the descending run.
    @(negedge clk);
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    cnt = 0;
    while (!(cnt >= 50 && wen_a[0]) && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    chk("reach_down_phase", 64'(cnt < 400), 64'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs(0, "mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_idle_wen", 64'(wen_a[0]), 64'd0);
      chk("post_reset_idle_busy", 64'(busy_a[0]), 64'd0);
    end
    run_report(0, M_NOSTALL, n_acc, run_cyc, first_wd, peak, stalls, hold_cnt);
    chk("after_reset_writes", 64'(n_acc), 64'd44);
    chk("after_reset_runtime", 64'(run_cyc), 64'd87);

    // start held high through a whole report, then restart from DONE.
    run_report(0, M_HOLD, n_acc, run_cyc, first_wd, peak, stalls, hold_cnt);
    chk("hold_writes", 64'(n_acc), 64'd44);
    chk("hold_runtime", 64'(run_cyc), 64'd87);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
